// File: rtl/ftsd_bcd_counter_pkg.sv
// Shared types and constants for the seven-segment BCD counter block.
package ftsd_bcd_counter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // Force a preset nibble into the legal BCD range.
    function automatic logic [3:0] bcd_clamp(input logic [3:0] n);
        return (n > BCD_MAX) ? BCD_MAX : n;
    endfunction

endpackage

// File: rtl/ftsd_bcd_counter_digit.sv
// One BCD digit of the up/down counter, chained to its neighbours through
// step enable (carry/borrow in) and the terminal-count flag (carry/borrow out).
module bcd_digit
    import ftsd_bcd_counter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       step,
    input  logic       dir,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       clear,
    output logic [3:0] digit,
    output logic       tc
);

    // Terminal count: the digit that rolls over on this step in this direction.
    assign tc = dir ? (digit == BCD_MAX) : (digit == 4'd0);

    // Digit register: clear beats load beats step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            digit <= 4'd0;
        else if (clear)
            digit <= 4'd0;
        else if (load)
            digit <= bcd_clamp(load_val);
        else if (step) begin
            if (dir)
                digit <= tc ? 4'd0 : digit + 4'd1;
            else
                digit <= tc ? BCD_MAX : digit - 4'd1;
        end
    end

endmodule

// File: rtl/ftsd_bcd_counter.sv
// Four-digit BCD up/down counter with run/pause/idle control, a step
// prescaler and a free-running scan counter feeding the display mux.
module ftsd_bcd_counter
    import ftsd_bcd_counter_pkg::*;
#(
    parameter int TICK_DIV  = 400000,
    parameter int SCAN_BITS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_stop,
    input  logic        clear,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        dir,
    output logic [3:0]  dig3,
    output logic [3:0]  dig2,
    output logic [3:0]  dig1,
    output logic [3:0]  dig0,
    output logic [1:0]  scan_sel,
    output logic        running,
    output logic        done,
    output logic        wrap
);

    localparam int PRE_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    state_t               state, state_n;
    logic [PRE_W-1:0]     pre, pre_n;
    logic [SCAN_BITS-1:0] scan;
    logic [3:0][3:0]      digs;
    logic [3:0]           tc;
    logic [4:0]           en;
    logic                 load_ok, ss_ok, tick, step, hit_zero, hit_wrap;

    // Resolve coincident pulses: clear > load (not in RUN) > start_stop.
    assign load_ok  = load & ~clear & (state != ST_RUN);
    assign ss_ok    = start_stop & ~clear & ~load_ok;
    assign tick     = (pre == PRE_W'(TICK_DIV - 1));
    // A start_stop in RUN pauses on that edge instead of stepping, so the
    // partial period survives intact for the resume.
    assign step     = (state == ST_RUN) & ~clear & ~ss_ok & tick;
    assign hit_zero = step & ~dir & (digs == 16'h0001);
    assign hit_wrap = step &  dir & (digs == 16'h9999);

    // Carry/borrow ripple: a digit steps when all lower digits are terminal.
    assign en[0] = step;
    for (genvar i = 0; i < 4; i++) begin : g_dig
        bcd_digit u_dig (
            .clk      (clk),
            .rst      (rst),
            .step     (en[i]),
            .dir      (dir),
            .load     (load_ok),
            .load_val (load_val[4*i +: 4]),
            .clear    (clear),
            .digit    (digs[i]),
            .tc       (tc[i])
        );
        assign en[i+1] = en[i] & tc[i];
    end

    // Next-state and prescaler logic.
    always_comb begin
        state_n = state;
        pre_n   = pre;
        if (clear) begin
            state_n = ST_IDLE;
            pre_n   = '0;
        end else if (load_ok) begin
            pre_n   = '0;
        end else if (ss_ok) begin
            unique case (state)
                ST_IDLE: begin
                    // Counting down from zero would finish instantly; refuse.
                    if (dir || (digs != 16'h0000)) begin
                        state_n = ST_RUN;
                        pre_n   = '0;
                    end
                end
                ST_RUN:   state_n = ST_PAUSE;
                ST_PAUSE: state_n = ST_RUN;
                default:  state_n = ST_IDLE;
            endcase
        end else if (state == ST_RUN) begin
            pre_n = tick ? '0 : pre + PRE_W'(1);
            if (hit_zero)
                state_n = ST_IDLE;
        end
    end

    // State, prescaler, pulse and scan registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            pre     <= '0;
            running <= 1'b0;
            done    <= 1'b0;
            wrap    <= 1'b0;
            scan    <= '0;
        end else begin
            state   <= state_n;
            pre     <= pre_n;
            running <= (state_n == ST_RUN);
            done    <= hit_zero;
            wrap    <= hit_wrap;
            scan    <= scan + SCAN_BITS'(1);
        end
    end

    assign scan_sel = scan[SCAN_BITS-1 -: 2];
    assign dig3     = digs[3];
    assign dig2     = digs[2];
    assign dig1     = digs[1];
    assign dig0     = digs[0];

endmodule

// File: tb/tb_ftsd_bcd_counter.sv
// Scoreboard bench: the driver updates an integer-count reference model and
// queues the expected outputs; a monitor checks them after every clock edge.
module tb_ftsd_bcd_counter;

    localparam int TD = 4;
    localparam int SB = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_stop, clear, load, dir;
    logic [15:0] load_val;
    logic [3:0]  dig3, dig2, dig1, dig0;
    logic [1:0]  scan_sel;
    logic        running, done, wrap;

    ftsd_bcd_counter #(.TICK_DIV(TD), .SCAN_BITS(SB)) dut (
        .clk(clk), .rst(rst), .start_stop(start_stop), .clear(clear),
        .load(load), .load_val(load_val), .dir(dir),
        .dig3(dig3), .dig2(dig2), .dig1(dig1), .dig0(dig0),
        .scan_sel(scan_sel), .running(running), .done(done), .wrap(wrap)
    );

    always #5 clk = ~clk;

    // Reference model: state 0=idle 1=run 2=pause, count as plain integer.
    int m_st, m_cnt, m_pre, m_scan;
    int n_vec = 0, n_bad = 0;
    logic [20:0] exp_q[$];

    function automatic int clamp_val(input logic [15:0] v);
        int r = 0, p = 1;
        for (int i = 0; i < 4; i++) begin
            int n = (v >> (4 * i)) & 15;
            if (n > 9) n = 9;
            r += n * p;
            p *= 10;
        end
        return r;
    endfunction

    function automatic logic [15:0] to_bcd(input int c);
        logic [15:0] r;
        r[15:12] = 4'((c / 1000) % 10);
        r[11:8]  = 4'((c / 100) % 10);
        r[7:4]   = 4'((c / 10) % 10);
        r[3:0]   = 4'(c % 10);
        return r;
    endfunction

    task automatic model_reset();
        m_st = 0; m_cnt = 0; m_pre = 0; m_scan = 0;
    endtask

    // Apply one cycle of inputs, advance the model over the coming edge,
    // queue the expectation and move on to the next falling edge.
    task automatic cyc(input logic s, input logic c, input logic l,
                       input logic [15:0] v, input logic d);
        logic e_done = 1'b0, e_wrap = 1'b0;
        start_stop = s; clear = c; load = l; load_val = v; dir = d;
        if (c) begin
            m_cnt = 0; m_pre = 0; m_st = 0;
        end else if (l && m_st != 1) begin
            m_cnt = clamp_val(v); m_pre = 0;
        end else if (s) begin
            if (m_st == 0) begin
                if (!(d == 1'b0 && m_cnt == 0)) begin m_st = 1; m_pre = 0; end
            end else if (m_st == 1) m_st = 2;
            else m_st = 1;
        end else if (m_st == 1) begin
            if (m_pre == TD - 1) begin
                m_pre = 0;
                if (d) begin
                    m_cnt = (m_cnt + 1) % 10000;
                    if (m_cnt == 0) e_wrap = 1'b1;
                end else begin
                    m_cnt = (m_cnt + 9999) % 10000;
                    if (m_cnt == 0) begin e_done = 1'b1; m_st = 0; end
                end
            end else m_pre++;
        end
        m_scan = (m_scan + 1) % (1 << SB);
        exp_q.push_back({to_bcd(m_cnt), 2'(m_scan >> (SB - 2)),
                         (m_st == 1), e_done, e_wrap});
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic d);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 16'h0, d);
    endtask

    // Monitor: every registered output is valid one delta after the edge.
    always @(posedge clk) begin
        logic [20:0] e, g;
        #1;
        if (!rst && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = {dig3, dig2, dig1, dig0, scan_sel, running, done, wrap};
            n_vec++;
            if (g !== e) begin
                n_bad++;
                $display("FAIL cycle t=%0t: got dig=%h sel=%b run=%b done=%b wrap=%b, want dig=%h sel=%b run=%b done=%b wrap=%b",
                         $time, g[20:5], g[4:3], g[2], g[1], g[0],
                         e[20:5], e[4:3], e[2], e[1], e[0]);
            end
        end
    end

    initial begin
        rst = 1'b1; start_stop = 0; clear = 0; load = 0; load_val = 0; dir = 1;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Scan sequence from reset while idle.
        idle(16, 1'b1);

        // Up wrap 9998 -> 9999 -> 0000 with wrap pulse, keeps running.
        cyc(0, 0, 1, 16'h9998, 1);
        cyc(1, 0, 0, 16'h0, 1);
        idle(10, 1'b1);
        cyc(0, 1, 0, 16'h0, 1);

        // Down from 0010 to 0000, done pulse, then start is refused at zero.
        cyc(0, 0, 1, 16'h0010, 0);
        cyc(1, 0, 0, 16'h0, 0);
        idle(42, 1'b0);
        cyc(1, 0, 0, 16'h0, 0);
        idle(6, 1'b0);

        // Pause two cycles into a period, hold, resume.
        cyc(1, 0, 0, 16'h0, 1);
        idle(6, 1'b1);
        cyc(1, 0, 0, 16'h0, 1);
        idle(10, 1'b1);
        cyc(1, 0, 0, 16'h0, 1);
        idle(6, 1'b1);

        // Coincident pulses in PAUSE, then clamped load in PAUSE.
        cyc(1, 0, 0, 16'h0, 1);
        cyc(1, 1, 1, 16'h1234, 1);
        idle(2, 1'b1);
        cyc(0, 0, 1, 16'h0500, 1);
        cyc(1, 0, 0, 16'h0, 1);
        idle(2, 1'b1);
        cyc(1, 0, 0, 16'h0, 1);
        cyc(0, 0, 1, 16'h12F4, 1);
        idle(2, 1'b1);
        cyc(1, 1'b0, 1'b1, 16'h4444, 1);  // load+start in PAUSE: load wins
        cyc(1, 0, 0, 16'h0, 1);
        cyc(0, 0, 1, 16'h7777, 1);        // load in RUN is ignored
        idle(6, 1'b1);
        cyc(0, 1, 0, 16'h0, 1);

        // Asynchronous reset mid-count at 0123.
        cyc(0, 0, 1, 16'h0123, 1);
        cyc(1, 0, 0, 16'h0, 1);
        idle(2, 1'b1);
        @(posedge clk);
        #2;
        start_stop = 0; clear = 0; load = 0;
        rst = 1'b1;
        #1;
        n_vec++;
        if ({dig3, dig2, dig1, dig0, scan_sel, running, done, wrap} !== 21'h0) begin
            n_bad++;
            $display("FAIL async_reset: got dig=%h%h%h%h sel=%b run=%b done=%b wrap=%b, want all zero",
                     dig3, dig2, dig1, dig0, scan_sel, running, done, wrap);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        // Randomized pulses, presets (including illegal nibbles) and direction.
        begin
            logic d = 1'b1;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 49) == 0) d = ~d;
                cyc($urandom_range(0, 15) == 0, $urandom_range(0, 99) == 0,
                    $urandom_range(0, 31) == 0, 16'($urandom), d);
            end
        end
        idle(2, 1'b1);

        @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
